// File: rtl/guess_pkg.sv
// guess_pkg: shared widths, state encoding and helpers for the guess checker.
`default_nettype none

package guess_pkg;

  localparam int NUM_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;
  localparam logic [1:0] ST_LOSE = 2'd3;

  // Saturating decrement so the attempt counter can never wrap below zero.
  function automatic logic [NUM_WIDTH-1:0] dec_sat(input logic [NUM_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
// edge_detect: registers a level and flags its rising and falling transitions.
`default_nettype none

module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic r_level_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= level;
    end
  end

  assign rise = ~r_level_q & level;
  assign fall = r_level_q & ~level;

endmodule

`default_nettype wire

// File: rtl/guess_checker.sv
// guess_checker: latches a random target on button release and scores
// a bounded number of player guesses against it.
`default_nettype none

module guess_checker
  import guess_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 button,
  input  logic [NUM_WIDTH-1:0] random_number,
  input  logic [NUM_WIDTH-1:0] guess,
  input  logic                 guess_enter,
  output logic                 playing,
  output logic                 too_high,
  output logic                 too_low,
  output logic                 win,
  output logic                 lose,
  output logic [NUM_WIDTH-1:0] attempts_left,
  output logic [NUM_WIDTH-1:0] reveal
);

  localparam logic [NUM_WIDTH-1:0] C_MAX_ATTEMPTS = NUM_WIDTH'(MAX_ATTEMPTS);

  logic                 w_rel;
  logic                 w_sub;
  logic                 w_btn_rise;
  logic                 w_ge_fall;
  logic                 w_unused_edges;
  logic                 w_gt;
  logic                 w_eq;

  state_t               r_state;
  logic [NUM_WIDTH-1:0] r_target;
  logic [NUM_WIDTH-1:0] r_attempts;
  logic                 r_too_high;
  logic                 r_too_low;
  logic                 r_win;
  logic                 r_lose;
  logic [NUM_WIDTH-1:0] r_reveal;

  edge_detect u_button_edge (
    .clock (clock),
    .reset (reset),
    .level (button),
    .rise  (w_btn_rise),
    .fall  (w_rel)
  );

  edge_detect u_enter_edge (
    .clock (clock),
    .reset (reset),
    .level (guess_enter),
    .rise  (w_sub),
    .fall  (w_ge_fall)
  );

  assign w_unused_edges = w_btn_rise | w_ge_fall;

  assign w_gt = (guess > r_target);
  assign w_eq = (guess == r_target);

  // A release always restarts the game and takes priority over a
  // guess submitted on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_attempts <= '0;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_reveal   <= '0;
    end else if (w_rel) begin
      r_state    <= ST_PLAY;
      r_target   <= random_number;
      r_attempts <= C_MAX_ATTEMPTS;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_reveal   <= '0;
    end else if (w_sub && (r_state == ST_PLAY)) begin
      if (w_eq) begin
        r_win      <= 1'b1;
        r_too_high <= 1'b0;
        r_too_low  <= 1'b0;
        r_state    <= ST_WIN;
      end else begin
        r_too_high <= w_gt;
        r_too_low  <= ~w_gt;
        r_attempts <= dec_sat(r_attempts);
        // Last wrong guess: keep the direction flag visible alongside lose.
        if (r_attempts <= NUM_WIDTH'(1)) begin
          r_lose   <= 1'b1;
          r_state  <= ST_LOSE;
          r_reveal <= r_target;
        end
      end
    end
  end

  assign playing       = (r_state == ST_PLAY);
  assign too_high      = r_too_high;
  assign too_low       = r_too_low;
  assign win           = r_win;
  assign lose          = r_lose;
  assign attempts_left = r_attempts;
  assign reveal        = r_reveal;

endmodule

`default_nettype wire

// File: tb/tb_guess_checker.sv
// tb_guess_checker: directed self-checking bench for guess_checker.
`default_nettype none

module tb_guess_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       guess_enter = 1'b0;
  logic [3:0] random_number = 4'd0;
  logic [3:0] guess = 4'd0;
  logic       playing;
  logic       too_high;
  logic       too_low;
  logic       win;
  logic       lose;
  logic [3:0] attempts_left;
  logic [3:0] reveal;

  int vectors = 0;
  int miscompares = 0;

  guess_checker #(.MAX_ATTEMPTS(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .random_number (random_number),
    .guess         (guess),
    .guess_enter   (guess_enter),
    .playing       (playing),
    .too_high      (too_high),
    .too_low       (too_low),
    .win           (win),
    .lose          (lose),
    .attempts_left (attempts_left),
    .reveal        (reveal)
  );

  always #5 clock = ~clock;

  // Packed view: {playing, too_high, too_low, win, lose, attempts_left, reveal}
  function automatic logic [12:0] outs();
    return {playing, too_high, too_low, win, lose, attempts_left, reveal};
  endfunction

  function automatic logic [12:0] pk(input logic p, input logic h, input logic l,
                                     input logic w, input logic lo,
                                     input logic [3:0] att, input logic [3:0] rev);
    return {p, h, l, w, lo, att, rev};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_release(input logic [3:0] rn);
    random_number = rn;
    button = 1'b1;
    repeat (3) tick();
    button = 1'b0;
    tick();
  endtask

  // Drops guess_enter for a cycle, then raises it; returns right after the scoring edge.
  task automatic enter_guess(input logic [3:0] g);
    guess_enter = 1'b0;
    tick();
    guess = g;
    guess_enter = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    for (int i = 0; i < 4; i++) begin
      button = i[0];
      guess_enter = ~i[0];
      random_number = 4'(i + 9);
      guess = 4'(i);
      tick();
    end
    obs = outs();
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", obs, 13'd0);
    end
    button = 1'b0;
    guess_enter = 1'b0;
    reset = 1'b1;
    tick();
    guess_enter = 1'b1;
    tick();
    obs = outs();
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL idle_guess: got %b want %b", obs, 13'd0);
    end
    guess_enter = 1'b0;
    tick();
  endtask

  task automatic test_win();
    logic [12:0] obs;
    do_release(4'd10);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 0, 0, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL arm10: got %b want %b", obs, pk(1, 0, 0, 0, 0, 4'd5, 4'd0));
    end
    enter_guess(4'd12);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 1, 0, 0, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL guess12: got %b want %b", obs, pk(1, 1, 0, 0, 0, 4'd4, 4'd0));
    end
    enter_guess(4'd3);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 1, 0, 0, 4'd3, 4'd0)) begin
      miscompares++;
      $display("FAIL guess3: got %b want %b", obs, pk(1, 0, 1, 0, 0, 4'd3, 4'd0));
    end
    enter_guess(4'd10);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 0, 1, 0, 4'd3, 4'd0)) begin
      miscompares++;
      $display("FAIL guess10_win: got %b want %b", obs, pk(0, 0, 0, 1, 0, 4'd3, 4'd0));
    end
    enter_guess(4'd0);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 0, 1, 0, 4'd3, 4'd0)) begin
      miscompares++;
      $display("FAIL win_ignore: got %b want %b", obs, pk(0, 0, 0, 1, 0, 4'd3, 4'd0));
    end
  endtask

  task automatic test_lose();
    logic [12:0] obs;
    logic [12:0] want;
    do_release(4'd13);
    for (int i = 1; i <= 5; i++) begin
      enter_guess(4'd0);
      obs = outs();
      want = (i < 5) ? pk(1, 0, 1, 0, 0, 4'(5 - i), 4'd0)
                     : pk(0, 0, 1, 0, 1, 4'd0, 4'd13);
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL lose_step%0d: got %b want %b", i, obs, want);
      end
    end
    enter_guess(4'd0);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 1, 0, 1, 4'd0, 4'd13)) begin
      miscompares++;
      $display("FAIL lose_sixth: got %b want %b", obs, pk(0, 0, 1, 0, 1, 4'd0, 4'd13));
    end
    guess_enter = 1'b0;
    do_release(4'd2);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 0, 0, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL rearm2: got %b want %b", obs, pk(1, 0, 0, 0, 0, 4'd5, 4'd0));
    end
    enter_guess(4'd2);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 0, 1, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL rearm2_win: got %b want %b", obs, pk(0, 0, 0, 1, 0, 4'd5, 4'd0));
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs;
    guess_enter = 1'b0;
    do_release(4'd5);
    enter_guess(4'd7);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 1, 0, 0, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL b2b_pre: got %b want %b", obs, pk(1, 1, 0, 0, 0, 4'd4, 4'd0));
    end
    guess_enter = 1'b0;
    random_number = 4'd11;
    button = 1'b1;
    tick();
    button = 1'b0;
    guess = 4'd0;
    guess_enter = 1'b1;
    tick();
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 0, 0, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL rel_and_sub: got %b want %b", obs, pk(1, 0, 0, 0, 0, 4'd5, 4'd0));
    end
    enter_guess(4'd0);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 1, 0, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL held_first: got %b want %b", obs, pk(1, 0, 1, 0, 0, 4'd4, 4'd0));
    end
    repeat (9) tick();
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 1, 0, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL held_10cyc: got %b want %b", obs, pk(1, 0, 1, 0, 0, 4'd4, 4'd0));
    end
    enter_guess(4'd11);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 0, 1, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL target11_win: got %b want %b", obs, pk(0, 0, 0, 1, 0, 4'd4, 4'd0));
    end
  endtask

  task automatic test_midreset();
    logic [12:0] obs;
    guess_enter = 1'b0;
    do_release(4'd7);
    enter_guess(4'd9);
    obs = outs();
    vectors++;
    if (obs !== pk(1, 1, 0, 0, 0, 4'd4, 4'd0)) begin
      miscompares++;
      $display("FAIL mid_pre: got %b want %b", obs, pk(1, 1, 0, 0, 0, 4'd4, 4'd0));
    end
    #2;
    reset = 1'b0;
    #1;
    obs = outs();
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", obs, 13'd0);
    end
    button = 1'b1;
    guess = 4'd7;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    obs = outs();
    vectors++;
    if (obs !== 13'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want %b", obs, 13'd0);
    end
    button = 1'b0;
    tick();
    obs = outs();
    vectors++;
    if (obs !== pk(1, 0, 0, 0, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL post_reset_arm: got %b want %b", obs, pk(1, 0, 0, 0, 0, 4'd5, 4'd0));
    end
    enter_guess(4'd7);
    obs = outs();
    vectors++;
    if (obs !== pk(0, 0, 0, 1, 0, 4'd5, 4'd0)) begin
      miscompares++;
      $display("FAIL post_reset_win: got %b want %b", obs, pk(0, 0, 0, 1, 0, 4'd5, 4'd0));
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/guess_checker.md
# guess_checker

Consumer side of the 4-bit random-number counter. It latches the counter's `random_number` when the player releases `button`, then scores a sequence of player guesses against that target. Each guess yields higher/lower/equal feedback and consumes one attempt. It ends in a win or a loss and sits between the counter and the board's LED/7-segment drivers.

## Interface
- `MAX_ATTEMPTS`, default 5: guesses per game; legal range 1..15.
- `clock`  in  1: single system clock; all state updates on posedge.
- `reset`  in  1: asynchronous, active-low; 0 forces reset state immediately.
- `button`  in  1: same active-high level the counter sees; a 1→0 release arms a game.
- `random_number`  in  4: counter output; sampled only on the `button` release edge.
- `guess`  in  4: player's guess, unsigned.
- `guess_enter`  in  1: active-high level; each 0→1 rise submits `guess` once.
- `playing`  out  1: a game is in progress.
- `too_high`  out  1: last scored guess > target.
- `too_low`  out  1: last scored guess < target.
- `win`  out  1: target guessed.
- `lose`  out  1: attempts exhausted.
- `attempts_left`  out  4: remaining guesses.
- `reveal`  out  4: equals target in LOSE, 0 otherwise.

## Operation
- States:
  - IDLE: after reset.
  - PLAY: game in progress.
  - WIN: target guessed.
  - LOSE: attempts exhausted.
- Edge detection:
  - Both `button` and `guess_enter` are registered each clock (`*_q`; reset value 0).
  - rel = `button_q` & ~`button`.
  - sub = ~`guess_enter_q` & `guess_enter`.
- rel in any state:
  - target ← `random_number`; state → PLAY; `attempts_left` ← MAX_ATTEMPTS.
  - too_high/too_low/win/lose/reveal ← 0.
- sub in PLAY with no rel, comparing unsigned 4-bit:
  - `guess` == target: win ← 1, too_high/too_low ← 0, state → WIN; `attempts_left` unchanged.
  - `guess` > target: too_high ← 1, too_low ← 0, `attempts_left` − 1.
  - `guess` < target: too_low ← 1, too_high ← 0, `attempts_left` − 1.
  - Wrong guess with `attempts_left` == 1: `attempts_left` ← 0, lose ← 1, state → LOSE; the last too_high/too_low stays visible.
- sub in IDLE, WIN or LOSE: ignored, no output changes.
- rel and sub on the same edge: rel wins (new game) and the guess is discarded.
- Holding `guess_enter` high scores exactly one guess; it must return to 0 before the next guess counts.
- `attempts_left` never wraps below 0.
- `playing` = (state == PLAY).
- Reset values: state IDLE, target 0, every output 0 (including `attempts_left`), edge registers 0.

## Timing
- All outputs are registered; none are combinational from inputs.
- Release latency: `button` low is sampled at posedge N with `button_q`=1 from N−1. Target, `playing` and `attempts_left` are valid after posedge N.
- Guess latency: `guess_enter` high is sampled at posedge N with `guess_enter_q`=0. Flags and `attempts_left` are valid after posedge N.
- `guess` and `random_number` must be stable at the scoring/capture edge; no synchronizers are inside, and the top level debounces and synchronizes the buttons.
- Reset mid-game:
  - Outputs go to 0 immediately, asynchronously.
  - After deassertion, `guess_enter` already high registers as a rise but is ignored in IDLE.
  - `button` already high needs a release to arm.

## Structure
- Package `guess_pkg`:
  - state typedef/encoding (IDLE, PLAY, WIN, LOSE).
  - NUM_WIDTH = 4.
- Sub-module `edge_detect`:
  - Ports: clock, reset, level in; rise, fall out.
  - Instantiated twice: `button` uses fall, `guess_enter` uses rise.
- The top level holds the FSM, target register, attempt counter and flag registers.

## Test plan
- Reset held low with toggling inputs → all outputs 0, state IDLE; a `guess_enter` pulse after release → no change.
- `random_number`=10, `button` high 3 cycles then low → after the release edge: `playing`=1, `attempts_left`=5, flags 0.
- Target 10, guesses 12, 3, 10 → after each: too_high=1/4 left; too_low=1/3 left; win=1/3 left, `playing`=0.
- Target 13, five guesses of 0 → too_low each, `attempts_left` 4,3,2,1,0, lose=1, reveal=13. A sixth guess → no change. A new release with `random_number`=2 → PLAY, 5 left, reveal=0.
- In PLAY, release (`random_number`=11) and `guess_enter` rise on the same edge → target 11, 5 left, flags 0, guess not scored. `guess_enter` held 10 cycles → exactly one decrement.
- Reset asserted mid-cycle in PLAY → outputs 0 before the next posedge. After release, with `guess_enter` already high → still IDLE, no scoring.
